// File: rtl/subleq_pkg.sv
// rtl/subleq_pkg.sv - shared types and constants for the SUBLEQ RAM responder
// Purpose: state encoding, opcode values and default bus widths used by the
//          responder, its store and its interface.
// Ports:   none (package).
package subleq_pkg;

  localparam int DEF_ADR_W = 8;
  localparam int DEF_DAT_W = 8;

  localparam logic OPE_READ  = 1'b0;
  localparam logic OPE_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/subleq_ram_responder_if.sv
// rtl/subleq_ram_responder_if.sv - RAM strobe/bus bundle between control unit and responder
// Purpose: groups the request strobes, address/data buses and completion
//          signals of the SUBLEQ RAM handshake.
// Ports:   master = control unit (drives ram_ena/ram_ope/ram_ctl/adr/dat_in),
//          slave  = responder (drives dat_out/ram_rdy/busy).
interface subleq_ram_responder_if
  import subleq_pkg::*;
#(
  parameter int ADR_W = DEF_ADR_W,
  parameter int DAT_W = DEF_DAT_W
);

  logic             ram_ena;
  logic             ram_ope;
  logic             ram_ctl;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_in;
  logic [DAT_W-1:0] dat_out;
  logic             ram_rdy;
  logic             busy;

  modport master (
    output ram_ena, ram_ope, ram_ctl, adr, dat_in,
    input  dat_out, ram_rdy, busy
  );

  modport slave (
    input  ram_ena, ram_ope, ram_ctl, adr, dat_in,
    output dat_out, ram_rdy, busy
  );

endinterface

// File: rtl/subleq_ram_array.sv
// rtl/subleq_ram_array.sv - single-port word store for the SUBLEQ RAM responder
// Purpose: 2**ADR_W x DAT_W store, synchronous write, asynchronous read,
//          no reset (contents survive a responder reset).
// Ports:   clk   - system clock
//          we    - write enable, sampled on rising clk
//          adr   - word address (read and write)
//          wdata - write data
//          rdata - word at adr
module subleq_ram_array #(
  parameter int ADR_W = 8,
  parameter int DAT_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADR_W-1:0] adr,
  input  logic [DAT_W-1:0] wdata,
  output logic [DAT_W-1:0] rdata
);

  logic [DAT_W-1:0] mem [2**ADR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[adr] <= wdata;
    end
  end

  assign rdata = mem[adr];

endmodule

// File: rtl/subleq_ram_responder.sv
// rtl/subleq_ram_responder.sv - wait-state RAM responder with four-phase ram_ena/ram_rdy handshake
// Purpose: captures a request from IDLE, spends WAIT_STATES cycles in WAIT,
//          performs the access in a one-cycle ACK (ram_rdy=1), then stays in
//          HOLD until the initiator drops ram_ena.
// Ports:   clk - system clock, rising edge
//          res - asynchronous active-low reset
//          bus - slave side of subleq_ram_responder_if
//                (ram_ena/ram_ope/ram_ctl/adr/dat_in in, dat_out/ram_rdy/busy out)
module subleq_ram_responder
  import subleq_pkg::*;
#(
  parameter int ADR_W       = DEF_ADR_W,
  parameter int DAT_W       = DEF_DAT_W,
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   res,
  subleq_ram_responder_if.slave  bus
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic [ADR_W-1:0] req_adr;
  logic             req_ope;
  logic [DAT_W-1:0] req_dat;
  logic [DAT_W-1:0] rd_lat;
  logic [DAT_W-1:0] mem_rdata;
  logic             mem_we;
  logic             accept;

  // A request is only taken from IDLE; HOLD absorbs a still-high ram_ena.
  assign accept = (state == IDLE) && bus.ram_ena;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.ram_ena) begin
          cnt_nxt   = WS;
          state_nxt = (WS == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        // Counter starts at WAIT_STATES, so leaving at 1 gives exactly
        // WAIT_STATES cycles in WAIT.
        if (cnt <= 4'd1) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!bus.ram_ena) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      req_adr <= '0;
      req_ope <= OPE_READ;
      req_dat <= '0;
      rd_lat  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_adr <= bus.adr;
        req_ope <= bus.ram_ope;
        req_dat <= bus.dat_in;
      end
      if ((state == ACK) && (req_ope == OPE_READ)) begin
        rd_lat <= mem_rdata;
      end
    end
  end

  // Write enable is decoded from the registered state, so an asynchronous
  // reset during WAIT/ACK drops it before the next edge and the write is lost.
  assign mem_we = (state == ACK) && (req_ope == OPE_WRITE);

  subleq_ram_array #(
    .ADR_W (ADR_W),
    .DAT_W (DAT_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .adr   (req_adr),
    .wdata (req_dat),
    .rdata (mem_rdata)
  );

  assign bus.ram_rdy = (state == ACK);
  assign bus.busy    = (state != IDLE);
  assign bus.dat_out = rd_lat & {DAT_W{bus.ram_ctl}};

endmodule

// File: tb/tb_subleq_ram_responder.sv
// tb/tb_subleq_ram_responder.sv - scoreboard bench for subleq_ram_responder at WAIT_STATES 0, 1 and 3
module tb_subleq_ram_responder;
  import subleq_pkg::*;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [7:0] dat;
  } exp_t;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       ena = 1'b0;
  logic       ope = 1'b0;
  logic       ctl = 1'b1;
  logic [7:0] adr_s = 8'h00;
  logic [7:0] din_s = 8'h00;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  int         ws_tab [3] = '{0, 1, 3};
  int         rdy_cnt [3] = '{0, 0, 0};
  exp_t       sb [3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  subleq_ram_responder_if #(.ADR_W(8), .DAT_W(8)) b0 ();
  subleq_ram_responder_if #(.ADR_W(8), .DAT_W(8)) b1 ();
  subleq_ram_responder_if #(.ADR_W(8), .DAT_W(8)) b3 ();

  assign b0.ram_ena = ena;   assign b1.ram_ena = ena;   assign b3.ram_ena = ena;
  assign b0.ram_ope = ope;   assign b1.ram_ope = ope;   assign b3.ram_ope = ope;
  assign b0.ram_ctl = ctl;   assign b1.ram_ctl = ctl;   assign b3.ram_ctl = ctl;
  assign b0.adr     = adr_s; assign b1.adr     = adr_s; assign b3.adr     = adr_s;
  assign b0.dat_in  = din_s; assign b1.dat_in  = din_s; assign b3.dat_in  = din_s;

  subleq_ram_responder #(.ADR_W(8), .DAT_W(8), .WAIT_STATES(0)) u_dut0 (.clk(clk), .res(res), .bus(b0));
  subleq_ram_responder #(.ADR_W(8), .DAT_W(8), .WAIT_STATES(1)) u_dut1 (.clk(clk), .res(res), .bus(b1));
  subleq_ram_responder #(.ADR_W(8), .DAT_W(8), .WAIT_STATES(3)) u_dut3 (.clk(clk), .res(res), .bus(b3));

  function automatic logic [7:0] dout(int k);
    case (k)
      0: dout = b0.dat_out;
      1: dout = b1.dat_out;
      default: dout = b3.dat_out;
    endcase
  endfunction

  function automatic logic rdy(int k);
    case (k)
      0: rdy = b0.ram_rdy;
      1: rdy = b1.ram_rdy;
      default: rdy = b3.ram_rdy;
    endcase
  endfunction

  function automatic logic bsy(int k);
    case (k)
      0: bsy = b0.busy;
      1: bsy = b1.busy;
      default: bsy = b3.busy;
    endcase
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ws=%0d: got 0x%0h expected 0x%0h", name, ws_tab[k], act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ram_rdy and checks the read latch
  // one cycle later.
  bit         pend_rd [3] = '{0, 0, 0};
  logic [7:0] pend_dat [3];
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (pend_rd[k]) begin
          chk("read_data", k, int'(dout(k)), int'(pend_dat[k] & {8{ctl}}));
          pend_rd[k] = 1'b0;
        end
        if (rdy(k) === 1'b1) begin
          rdy_cnt[k]++;
          if (sb[k].size() == 0) begin
            chk("unexpected_rdy", k, 1, 0);
          end else begin
            exp_t e;
            e = sb[k].pop_front();
            chk("rdy_cycle", k, cyc, e.cyc);
            if (e.rd) begin
              pend_rd[k]  = 1'b1;
              pend_dat[k] = e.dat;
            end
          end
        end
      end
    end
  end

  // One request; for reads d is the expected data. early drops ram_ena right
  // after the sampling edge; alt changes adr/dat_in after that edge.
  task automatic req(input bit w, input logic [7:0] a, input logic [7:0] d, input int hold,
                     input bit early, input bit alt, input logic [7:0] aa, input logic [7:0] ad);
    int  base [3];
    bit  done;
    @(negedge clk);
    ope   = w;
    adr_s = a;
    din_s = w ? d : 8'h00;
    ena   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e.cyc = cyc + 1 + ws_tab[k];
      e.rd  = !w;
      e.dat = d;
      sb[k].push_back(e);
      base[k] = rdy_cnt[k];
    end
    if (early || alt) begin
      @(posedge clk);
      #1;
      if (early) ena = 1'b0;
      if (alt) begin
        adr_s = aa;
        din_s = ad;
      end
    end
    done = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      #1;
      done = (rdy_cnt[0] > base[0]) && (rdy_cnt[1] > base[1]) && (rdy_cnt[2] > base[2]);
    end
    chk("rdy_seen", 0, int'(done), 1);
    if (!early) begin
      repeat (hold) begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk("busy_hold", k, int'(bsy(k)), 1);
      end
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
    end else begin
      @(negedge clk);
      @(negedge clk);
    end
    #1;
    for (int k = 0; k < 3; k++) chk("busy_fall", k, int'(bsy(k)), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("reset_dat_out", k, int'(dout(k)), 0);
    res = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("idle_dat_out", k, int'(dout(k)), 0);
        chk("idle_rdy", k, int'(rdy(k)), 0);
        chk("idle_busy", k, int'(bsy(k)), 0);
      end
      chk("idle_state", 1, int'(u_dut1.state), int'(IDLE));
    end

    // Write then read, ram_ctl gating.
    req(1'b1, 8'h10, 8'h5A, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    req(1'b0, 8'h10, 8'h5A, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    ctl = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ctl_off", k, int'(dout(k)), 8'h00);
    ctl = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("ctl_on", k, int'(dout(k)), 8'h5A);

    // Inputs changed after capture are ignored.
    req(1'b1, 8'h02, 8'h77, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    req(1'b1, 8'h01, 8'h33, 0, 1'b0, 1'b1, 8'h02, 8'h99);
    req(1'b0, 8'h01, 8'h33, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    req(1'b0, 8'h02, 8'h77, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    // ram_ena held long past ACK: one pulse, busy until release.
    req(1'b1, 8'h30, 8'hC3, 6, 1'b0, 1'b0, 8'h00, 8'h00);
    req(1'b0, 8'h30, 8'hC3, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    // ram_ena dropped before ACK still completes the write.
    req(1'b1, 8'h40, 8'h11, 0, 1'b1, 1'b0, 8'h00, 8'h00);
    req(1'b0, 8'h40, 8'h11, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    // Reset during WAIT (ACK for the zero-wait instance) discards the write.
    req(1'b1, 8'h20, 8'hFF, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    ope   = 1'b1;
    adr_s = 8'h20;
    din_s = 8'h00;
    ena   = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    ena = 1'b0;
    repeat (2) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk("rst_dat_out", k, int'(dout(k)), 0);
        chk("rst_rdy", k, int'(rdy(k)), 0);
        chk("rst_busy", k, int'(bsy(k)), 0);
      end
    end
    res = 1'b1;
    req(1'b0, 8'h20, 8'hFF, 0, 1'b0, 1'b0, 8'h00, 8'h00);

    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++) chk("sb_empty", k, sb[k].size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
